// File: rtl/glip_stream_checker_if.sv
// Valid/ready stream bundle carrying the host-to-device FIFO words into the checker.
// The master drives data and valid; the slave answers with ready.
interface glip_stream_checker_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/glip_stream_checker.sv
// Sink-side traffic checker: verifies that the incoming stream is a contiguous incrementing
// sequence modulo 2^WIDTH. It reports lock, mismatches and word counts, with optional throttling.
module glip_stream_checker #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned ERRCNT_WIDTH   = 16,
  parameter int unsigned THROTTLE_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [THROTTLE_WIDTH-1:0] throttle,
  glip_stream_checker_if.slave      stream,
  output logic                      synced,
  output logic                      error,
  output logic [ERRCNT_WIDTH-1:0]   error_count,
  output logic [31:0]               word_count
);

  typedef enum logic [1:0] {StIdle, StSync, StCheck} state_e;

  state_e                    state_q;
  logic [WIDTH-1:0]          expected_q;
  logic [THROTTLE_WIDTH-1:0] gap_q;
  logic                      xfer;

  // Ready depends only on registered state, never on valid.
  assign stream.in_ready = (state_q != StIdle) && (gap_q == '0);
  assign xfer            = stream.in_valid && stream.in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      expected_q  <= '0;
      gap_q       <= '0;
      synced      <= 1'b0;
      error       <= 1'b0;
      error_count <= '0;
      word_count  <= '0;
    end else begin
      error <= 1'b0;

      if (gap_q != '0) begin
        gap_q <= gap_q - 1'b1;
      end

      if (xfer) begin
        gap_q      <= throttle;
        word_count <= word_count + 32'd1;
      end

      unique case (state_q)
        StIdle: begin
          if (enable) begin
            state_q <= StSync;
          end
        end
        StSync: begin
          if (xfer) begin
            expected_q <= stream.in_data + 1'b1;
            synced     <= 1'b1;
            state_q    <= StCheck;
          end
        end
        StCheck: begin
          if (xfer) begin
            if (stream.in_data == expected_q) begin
              expected_q <= expected_q + 1'b1;
            end else begin
              // Resync to the received word so one dropped word costs exactly one error.
              error      <= 1'b1;
              expected_q <= stream.in_data + 1'b1;
              if (error_count != '1) begin
                error_count <= error_count + 1'b1;
              end
            end
          end
        end
        default: state_q <= StIdle;
      endcase

      // A word accepted in the cycle enable falls is still processed above.
      if (!enable) begin
        state_q <= StIdle;
        synced  <= 1'b0;
        gap_q   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_glip_stream_checker.sv
// Directed table-driven bench for glip_stream_checker, with a second instance using a
// 2-bit error counter for saturation and a hand-written throttle sequence.
module tb_glip_stream_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [3:0]  throttle;
  logic [7:0]  in_data;
  logic        in_valid;

  logic        synced_a, error_a, synced_b, error_b;
  logic [15:0] ec_a;
  logic [1:0]  ec_b;
  logic [31:0] wc_a, wc_b;

  int unsigned total_cnt = 0;
  int unsigned pass_cnt  = 0;

  glip_stream_checker_if #(.WIDTH(8)) if_a ();
  glip_stream_checker_if #(.WIDTH(8)) if_b ();

  assign if_a.in_data  = in_data;
  assign if_a.in_valid = in_valid;
  assign if_b.in_data  = in_data;
  assign if_b.in_valid = in_valid;

  glip_stream_checker #(.WIDTH(8), .ERRCNT_WIDTH(16), .THROTTLE_WIDTH(4)) dut_a (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .throttle    (throttle),
    .stream      (if_a),
    .synced      (synced_a),
    .error       (error_a),
    .error_count (ec_a),
    .word_count  (wc_a)
  );

  glip_stream_checker #(.WIDTH(8), .ERRCNT_WIDTH(2), .THROTTLE_WIDTH(4)) dut_b (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .throttle    (throttle),
    .stream      (if_b),
    .synced      (synced_b),
    .error       (error_b),
    .error_count (ec_b),
    .word_count  (wc_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        en;
    logic        vld;
    logic [7:0]  data;
    logic        rdy;
    logic        syn;
    logic        err;
    logic [31:0] wc;
    logic [15:0] ec;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic e, logic vl, logic [7:0] d, logic rd, logic s,
                              logic er, int w, int ec);
    vec_t t;
    t.rst = r; t.en = e; t.vld = vl; t.data = d;
    t.rdy = rd; t.syn = s; t.err = er; t.wc = w; t.ec = ec[15:0];
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  initial begin
    logic [15:0] ecb_exp;
    logic [7:0]  d;
    logic        err_seen;

    // T1 reset with valid high
    vecs.push_back(mk(1, 1, 1, 8'hAA, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 8'hAA, 0, 0, 0, 0, 0));
    // T2 wrap 0xFE..0x01
    vecs.push_back(mk(0, 1, 1, 8'hFE, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 8'hFE, 1, 1, 0, 1, 0));
    vecs.push_back(mk(0, 1, 1, 8'hFF, 1, 1, 0, 2, 0));
    vecs.push_back(mk(0, 1, 1, 8'h00, 1, 1, 0, 3, 0));
    vecs.push_back(mk(0, 1, 1, 8'h01, 1, 1, 0, 4, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 1, 1, 0, 4, 0));
    // T3 gap: 0x10,0x11,0x13,0x14
    vecs.push_back(mk(1, 1, 0, 8'h00, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 8'h10, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 8'h10, 1, 1, 0, 1, 0));
    vecs.push_back(mk(0, 1, 1, 8'h11, 1, 1, 0, 2, 0));
    vecs.push_back(mk(0, 1, 1, 8'h13, 1, 1, 1, 3, 1));
    vecs.push_back(mk(0, 1, 1, 8'h14, 1, 1, 0, 4, 1));
    vecs.push_back(mk(0, 1, 0, 8'h00, 1, 1, 0, 4, 1));
    // T5 disable / re-enable
    vecs.push_back(mk(1, 1, 0, 8'h00, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 8'h20, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 8'h20, 1, 1, 0, 1, 0));
    vecs.push_back(mk(0, 1, 1, 8'h21, 1, 1, 0, 2, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 0, 0, 2, 0));
    vecs.push_back(mk(0, 0, 1, 8'h22, 0, 0, 0, 2, 0));
    vecs.push_back(mk(0, 0, 1, 8'h22, 0, 0, 0, 2, 0));
    vecs.push_back(mk(0, 1, 1, 8'h50, 0, 0, 0, 2, 0));
    vecs.push_back(mk(0, 1, 1, 8'h50, 1, 1, 0, 3, 0));
    vecs.push_back(mk(0, 1, 1, 8'h51, 1, 1, 0, 4, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 1, 1, 0, 4, 0));
    // word offered as enable falls is still checked (expected 0x52)
    vecs.push_back(mk(0, 0, 1, 8'h60, 1, 0, 1, 5, 1));
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 5, 1));
    // T6 saturation: 0,5,0,5,0,5
    vecs.push_back(mk(1, 1, 0, 8'h00, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 8'h00, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 8'h00, 1, 1, 0, 1, 0));
    vecs.push_back(mk(0, 1, 1, 8'h05, 1, 1, 1, 2, 1));
    vecs.push_back(mk(0, 1, 1, 8'h00, 1, 1, 1, 3, 2));
    vecs.push_back(mk(0, 1, 1, 8'h05, 1, 1, 1, 4, 3));
    vecs.push_back(mk(0, 1, 1, 8'h00, 1, 1, 1, 5, 4));
    vecs.push_back(mk(0, 1, 1, 8'h05, 1, 1, 1, 6, 5));
    vecs.push_back(mk(0, 1, 0, 8'h00, 1, 1, 0, 6, 5));

    rst = 1'b1; enable = 1'b0; throttle = '0; in_data = '0; in_valid = 1'b0;
    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; enable = vecs[i].en; in_valid = vecs[i].vld; in_data = vecs[i].data;
      #1;
      check($sformatf("row%0d ready_a", i), 32'(if_a.in_ready), 32'(vecs[i].rdy));
      check($sformatf("row%0d ready_b", i), 32'(if_b.in_ready), 32'(vecs[i].rdy));
      @(posedge clk);
      #1;
      ecb_exp = (vecs[i].ec > 16'd3) ? 16'd3 : vecs[i].ec;
      check($sformatf("row%0d synced", i), 32'(synced_a), 32'(vecs[i].syn));
      check($sformatf("row%0d error_a", i), 32'(error_a), 32'(vecs[i].err));
      check($sformatf("row%0d error_b", i), 32'(error_b), 32'(vecs[i].err));
      check($sformatf("row%0d word_count", i), wc_a, vecs[i].wc);
      check($sformatf("row%0d error_count_a", i), 32'(ec_a), 32'(vecs[i].ec));
      check($sformatf("row%0d error_count_b", i), 32'(ec_b), 32'(ecb_exp));
    end

    // T4 throttle=3 with valid held high: ready pattern 1,0,0,0
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0; enable = 1'b1; throttle = 4'd3;
    @(negedge clk);
    d = 8'h40; err_seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_data = d;
      #1;
      check($sformatf("thr cyc%0d ready", i), 32'(if_a.in_ready), 32'((i % 4) == 0));
      if ((i % 4) == 0) d = d + 8'd1;
      @(posedge clk);
      #1;
      err_seen = err_seen | error_a;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("thr word_count", wc_a, 32'd4);
    check("thr error pulse", 32'(err_seen), 32'd0);
    check("thr error_count", 32'(ec_a), 32'd0);
    check("thr synced", 32'(synced_a), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
